// File: rtl/fetch_align_buffer.sv
// fetch_align_buffer: two-entry line buffer feeding a fetch-width extractor.
// Missing lines are filled through a line-request handshake; fetches that
// cross a line boundary are stitched together from both entries.
module fetch_align_buffer #(
    parameter int unsigned LINE_WIDTH  = 256,
    parameter int unsigned FETCH_WIDTH = 64,
    parameter int unsigned PC_WIDTH    = 64
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_flush,
    input  logic                   i_req_valid,
    input  logic [PC_WIDTH-1:0]    i_req_pc,
    output logic                   o_req_ready,
    output logic                   o_line_req_valid,
    output logic [PC_WIDTH-1:0]    o_line_req_addr,
    input  logic                   i_line_req_ready,
    input  logic                   i_line_resp_valid,
    input  logic [LINE_WIDTH-1:0]  i_line_resp_data,
    output logic                   o_fetch_valid,
    output logic [PC_WIDTH-1:0]    o_fetch_pc,
    output logic [FETCH_WIDTH-1:0] o_fetch_data,
    input  logic                   i_fetch_ready
);
    localparam int unsigned LB   = LINE_WIDTH / 8;
    localparam int unsigned FB   = FETCH_WIDTH / 8;
    localparam int unsigned OFFW = $clog2(LB);
    localparam int unsigned OW1  = OFFW + 1;

    if ((LINE_WIDTH < 64) || ((LINE_WIDTH & (LINE_WIDTH - 1)) != 0) ||
        (FETCH_WIDTH < 32) || ((FETCH_WIDTH & (FETCH_WIDTH - 1)) != 0) ||
        (FETCH_WIDTH > LINE_WIDTH) || (PC_WIDTH <= OFFW)) begin : g_param_check
        $error("fetch_align_buffer: illegal LINE_WIDTH/FETCH_WIDTH/PC_WIDTH");
    end

    typedef enum logic [2:0] {StIdle, StCheck, StMissReq, StMissWait, StOutput} state_e;

    state_e                 state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [PC_WIDTH-1:0]    tgt_q, tgt_d;
    logic [1:0]             ent_valid_q, ent_valid_d;
    logic [PC_WIDTH-1:0]    ent_tag_q [2];
    logic [PC_WIDTH-1:0]    ent_tag_d [2];
    logic [LINE_WIDTH-1:0]  ent_data_q [2];
    logic [LINE_WIDTH-1:0]  ent_data_d [2];
    logic                   drop_q, drop_d;
    logic                   fetch_valid_q, fetch_valid_d;
    logic [PC_WIDTH-1:0]    fetch_pc_q, fetch_pc_d;
    logic [FETCH_WIDTH-1:0] fetch_data_q, fetch_data_d;

    logic [PC_WIDTH-1:0]     line_a, line_b;
    logic [OFFW-1:0]         off;
    logic                    span, hit_a, hit_b;
    logic [LINE_WIDTH-1:0]   hi_data;
    logic [2*LINE_WIDTH-1:0] cat;
    logic                    req_fire, line_req_fire;

    // Decode the latched PC into line addresses, offset and hit status.
    always_comb begin
        line_a  = {pc_q[PC_WIDTH-1:OFFW], {OFFW{1'b0}}};
        line_b  = line_a + PC_WIDTH'(LB);
        off     = {pc_q[OFFW-1:1], 1'b0};
        span    = ({1'b0, off} + OW1'(FB)) > OW1'(LB);
        hit_a   = ent_valid_q[line_a[OFFW]] && (ent_tag_q[line_a[OFFW]] == line_a);
        hit_b   = ent_valid_q[line_b[OFFW]] && (ent_tag_q[line_b[OFFW]] == line_b);
        hi_data = span ? ent_data_q[line_b[OFFW]] : '0;
        cat     = {hi_data, ent_data_q[line_a[OFFW]]};
    end

    // Handshake outputs; the line request is held off while a stale response is owed.
    always_comb begin
        o_req_ready      = !i_rst && !i_flush &&
                           ((state_q == StIdle) || ((state_q == StOutput) && i_fetch_ready));
        o_line_req_valid = (state_q == StMissReq) && !drop_q;
        o_line_req_addr  = (state_q == StMissReq) ? tgt_q : '0;
        o_fetch_valid    = fetch_valid_q;
        o_fetch_pc       = fetch_pc_q;
        o_fetch_data     = fetch_data_q;
        req_fire         = i_req_valid && o_req_ready;
        line_req_fire    = o_line_req_valid && i_line_req_ready;
    end

    // Next-state logic: flush first, then the fetch FSM.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        tgt_d         = tgt_q;
        ent_valid_d   = ent_valid_q;
        ent_tag_d     = ent_tag_q;
        ent_data_d    = ent_data_q;
        drop_d        = drop_q;
        fetch_valid_d = fetch_valid_q;
        fetch_pc_d    = fetch_pc_q;
        fetch_data_d  = fetch_data_q;

        if (i_flush) begin
            state_d       = StIdle;
            pc_d          = '0;
            ent_valid_d   = '0;
            fetch_valid_d = 1'b0;
            // A response arriving with the flush settles whatever was owed.
            drop_d = line_req_fire ||
                     ((drop_q || (state_q == StMissWait)) && !i_line_resp_valid);
        end else begin
            if (drop_q && i_line_resp_valid) begin
                drop_d = 1'b0;
            end
            unique case (state_q)
                StIdle: begin
                    if (req_fire) begin
                        pc_d    = i_req_pc;
                        pc_d[0] = 1'b0;
                        state_d = StCheck;
                    end
                end
                StCheck: begin
                    if (!hit_a) begin
                        tgt_d   = line_a;
                        state_d = StMissReq;
                    end else if (span && !hit_b) begin
                        tgt_d   = line_b;
                        state_d = StMissReq;
                    end else begin
                        fetch_valid_d = 1'b1;
                        fetch_pc_d    = pc_q;
                        fetch_data_d  = FETCH_WIDTH'(cat >> {off, 3'b000});
                        state_d       = StOutput;
                    end
                end
                StMissReq: begin
                    if (line_req_fire) begin
                        state_d = StMissWait;
                    end
                end
                StMissWait: begin
                    if (i_line_resp_valid) begin
                        ent_valid_d[tgt_q[OFFW]] = 1'b1;
                        ent_tag_d[tgt_q[OFFW]]   = tgt_q;
                        ent_data_d[tgt_q[OFFW]]  = i_line_resp_data;
                        state_d                  = StCheck;
                    end
                end
                StOutput: begin
                    if (i_fetch_ready) begin
                        fetch_valid_d = 1'b0;
                        if (req_fire) begin
                            pc_d    = i_req_pc;
                            pc_d[0] = 1'b0;
                            state_d = StCheck;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= StIdle;
            pc_q          <= '0;
            tgt_q         <= '0;
            ent_valid_q   <= '0;
            ent_tag_q[0]  <= '0;
            ent_tag_q[1]  <= '0;
            drop_q        <= 1'b0;
            fetch_valid_q <= 1'b0;
            fetch_pc_q    <= '0;
            fetch_data_q  <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            tgt_q         <= tgt_d;
            ent_valid_q   <= ent_valid_d;
            ent_tag_q     <= ent_tag_d;
            drop_q        <= drop_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_pc_q    <= fetch_pc_d;
            fetch_data_q  <= fetch_data_d;
        end
    end

    // Line data storage; meaningful only while the entry valid bit is set.
    always_ff @(posedge i_clk) begin
        ent_data_q <= ent_data_d;
    end

endmodule

// File: tb/tb_fetch_align_buffer.sv
// tb_fetch_align_buffer: directed scenarios with queue-based scoreboards for
// fetch results and line requests, plus an in-order line responder.
module tb_fetch_align_buffer;
    logic         clk = 1'b0;
    logic         rst, flush, req_valid, req_ready;
    logic [63:0]  req_pc;
    logic         line_req_valid, line_req_ready;
    logic [63:0]  line_req_addr;
    logic         resp_valid;
    logic [255:0] resp_data;
    logic         fetch_valid, fetch_ready;
    logic [63:0]  fetch_pc, fetch_data;

    int n_tests = 0;
    int n_fail  = 0;
    int line_req_count = 0;
    bit hold_resp = 1'b0;

    logic [63:0] exp_pc_q[$];
    logic [63:0] exp_data_q[$];
    logic [63:0] exp_line_q[$];
    logic [63:0] pend_q[$];

    fetch_align_buffer #(
        .LINE_WIDTH (256),
        .FETCH_WIDTH(64),
        .PC_WIDTH   (64)
    ) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_flush          (flush),
        .i_req_valid      (req_valid),
        .i_req_pc         (req_pc),
        .o_req_ready      (req_ready),
        .o_line_req_valid (line_req_valid),
        .o_line_req_addr  (line_req_addr),
        .i_line_req_ready (line_req_ready),
        .i_line_resp_valid(resp_valid),
        .i_line_resp_data (resp_data),
        .o_fetch_valid    (fetch_valid),
        .o_fetch_pc       (fetch_pc),
        .o_fetch_data     (fetch_data),
        .i_fetch_ready    (fetch_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Byte k of a line is addr[7:0]+k; lines at 0x?2??? carry a distinct stale marker.
    function automatic logic [255:0] line_data(input logic [63:0] a);
        logic [255:0] d;
        for (int k = 0; k < 32; k++) begin
            d[8*k +: 8] = (a[15:12] == 4'h2) ? (8'hA5 ^ 8'(k)) : (a[7:0] + 8'(k));
        end
        return d;
    endfunction

    // Fetch result monitor.
    always @(negedge clk) begin
        if (!rst && fetch_valid && fetch_ready) begin
            if (exp_pc_q.size() == 0) begin
                check("unexpected_fetch", fetch_pc, 64'hx);
            end else begin
                check("fetch_pc", fetch_pc, exp_pc_q.pop_front());
                check("fetch_data", fetch_data, exp_data_q.pop_front());
            end
        end
    end

    // Line request monitor; accepted addresses feed the responder.
    always @(negedge clk) begin
        if (!rst && line_req_valid && line_req_ready) begin
            line_req_count++;
            if (exp_line_q.size() == 0) begin
                check("unexpected_line_req", line_req_addr, 64'hx);
            end else begin
                check("line_req_addr", line_req_addr, exp_line_q.pop_front());
            end
            pend_q.push_back(line_req_addr);
        end
    end

    // In-order line responder.
    initial begin
        logic [63:0] a;
        resp_valid = 1'b0;
        resp_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            resp_valid = 1'b0;
            if (!hold_resp && pend_q.size() > 0) begin
                a          = pend_q.pop_front();
                resp_valid = 1'b1;
                resp_data  = line_data(a);
            end
        end
    end

    task automatic issue(input logic [63:0] pc, input bit push, input logic [63:0] exp);
        int n;
        if (push) begin
            exp_pc_q.push_back({pc[63:1], 1'b0});
            exp_data_q.push_back(exp);
        end
        req_pc    = pc;
        req_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("req_accept", {63'd0, req_ready}, 64'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((exp_pc_q.size() != 0 || exp_line_q.size() != 0 || pend_q.size() != 0) &&
               n < 300) begin
            @(negedge clk);
            n++;
        end
        check(name, {63'd0, (exp_pc_q.size() == 0 && exp_line_q.size() == 0)}, 64'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  base;
        bit  bad;
        bit  bad_d, bad_p, bad_r;
        int  n;
        rst            = 1'b1;
        flush          = 1'b0;
        req_valid      = 1'b0;
        req_pc         = '0;
        line_req_ready = 1'b1;
        fetch_ready    = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", {63'd0, req_ready}, 64'd0);
        check("rst_line_req_valid", {63'd0, line_req_valid}, 64'd0);
        check("rst_line_req_addr", line_req_addr, 64'd0);
        check("rst_fetch_valid", {63'd0, fetch_valid}, 64'd0);
        check("rst_fetch_pc", fetch_pc, 64'd0);
        check("rst_fetch_data", fetch_data, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_req_ready", {63'd0, req_ready}, 64'd1);
        @(posedge clk);
        #1;

        // 1: cold aligned fetch
        exp_line_q.push_back(64'h1000);
        issue(64'h1000, 1'b1, 64'h0706050403020100);
        wait_done("t1_done");
        check("t1_line_reqs", 64'(line_req_count), 64'd1);

        // 2: hit at offset, two-cycle latency
        base = line_req_count;
        issue(64'h1018, 1'b1, 64'h1F1E1D1C1B1A1918);
        @(negedge clk);
        check("t2_valid_n1", {63'd0, fetch_valid}, 64'd0);
        @(negedge clk);
        check("t2_valid_n2", {63'd0, fetch_valid}, 64'd1);
        wait_done("t2_done");
        check("t2_line_reqs", 64'(line_req_count - base), 64'd0);

        // 3: line-spanning fetch
        base = line_req_count;
        exp_line_q.push_back(64'h1020);
        issue(64'h101C, 1'b1, 64'h232221201F1E1D1C);
        wait_done("t3_done");
        check("t3_line_reqs", 64'(line_req_count - base), 64'd1);

        // 4: flush while a line request is outstanding
        base = line_req_count;
        hold_resp = 1'b1;
        exp_line_q.push_back(64'h2000);
        issue(64'h2000, 1'b0, 64'h0);
        n = 0;
        while (pend_q.size() == 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("t4_miss_issued", 64'(pend_q.size()), 64'd1);
        @(posedge clk);
        #1;
        flush     = 1'b1;
        req_valid = 1'b1;
        req_pc    = 64'h3000;
        @(negedge clk);
        check("t4_flush_req_ready", {63'd0, req_ready}, 64'd0);
        @(posedge clk);
        #1;
        flush     = 1'b0;
        req_valid = 1'b0;
        exp_line_q.push_back(64'h3000);
        issue(64'h3000, 1'b1, 64'h0706050403020100);
        bad = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (line_req_valid) bad = 1'b1;
        end
        check("t4_no_req_while_drop", {63'd0, bad}, 64'd0);
        @(posedge clk);
        #1;
        hold_resp = 1'b0;
        wait_done("t4_done");
        check("t4_line_reqs", 64'(line_req_count - base), 64'd2);

        // 5: backpressure, then accept alongside the consuming handshake
        fetch_ready = 1'b0;
        issue(64'h3008, 1'b1, 64'h0F0E0D0C0B0A0908);
        n = 0;
        while (!fetch_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t5_valid", {63'd0, fetch_valid}, 64'd1);
        bad_d = 1'b0;
        bad_p = 1'b0;
        bad_r = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (fetch_data !== 64'h0F0E0D0C0B0A0908 || !fetch_valid) bad_d = 1'b1;
            if (fetch_pc !== 64'h3008) bad_p = 1'b1;
            if (req_ready !== 1'b0) bad_r = 1'b1;
        end
        check("t5_data_stable", {63'd0, bad_d}, 64'd0);
        check("t5_pc_stable", {63'd0, bad_p}, 64'd0);
        check("t5_req_ready_low", {63'd0, bad_r}, 64'd0);
        @(posedge clk);
        #1;
        fetch_ready = 1'b1;
        exp_pc_q.push_back(64'h3010);
        exp_data_q.push_back(64'h1716151413121110);
        req_valid = 1'b1;
        req_pc    = 64'h3010;
        @(negedge clk);
        check("t5_same_cycle_accept", {63'd0, req_ready}, 64'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        wait_done("t5_done");

        // 6: address wrap across the top of the address space
        base = line_req_count;
        exp_line_q.push_back(64'hFFFF_FFFF_FFFF_FFE0);
        exp_line_q.push_back(64'h0);
        issue(64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 64'h03020100FFFEFDFC);
        wait_done("t6_done");
        check("t6_line_reqs", 64'(line_req_count - base), 64'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
